// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and frame format.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int UART_DATA_BITS       = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 434;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signals between the raw rx line, the receive controller and the downstream SIPO.
interface uart_rx_ctrl_if;

    logic rx_i;
    logic shift_en_o;
    logic shift_bit_o;
    logic clear_o;
    logic rx_done_o;
    logic frame_err_o;
    logic busy_o;

    modport master (
        input  rx_i,
        output shift_en_o,
        output shift_bit_o,
        output clear_o,
        output rx_done_o,
        output frame_err_o,
        output busy_o
    );

    modport slave (
        output rx_i,
        input  shift_en_o,
        input  shift_bit_o,
        input  clear_o,
        input  rx_done_o,
        input  frame_err_o,
        input  busy_o
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 receive controller: start-bit qualification, mid-bit sampling and SIPO control pulses.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input logic            clk,
    input logic            rst,
    uart_rx_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);

    logic rx_s;
    logic rx_q;

    state_t           state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_next;
    logic [BIT_W-1:0] bit_cnt, bit_next;

    logic shift_en_q, shift_en_d;
    logic shift_bit_q, shift_bit_d;
    logic clear_q, clear_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic busy_q;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.rx_i),
        .q   (rx_s)
    );

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_next  = state;
        baud_next   = baud_cnt + 1'b1;
        bit_next    = bit_cnt;
        shift_en_d  = 1'b0;
        shift_bit_d = shift_bit_q;
        clear_d     = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state)
            IDLE: begin
                baud_next = '0;
                // Only a high-to-low transition starts a frame; a held-low line is ignored.
                if (rx_q && !rx_s) begin
                    clear_d    = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (baud_cnt == HALF_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_next   = '0;
                    shift_en_d  = 1'b1;
                    shift_bit_d = rx_s;
                    bit_next    = bit_cnt + 1'b1;
                    if (bit_cnt == DATA_LAST) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (baud_cnt == BIT_LAST) begin
                    baud_next  = '0;
                    state_next = IDLE;
                    done_d     = rx_s;
                    err_d      = !rx_s;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_cnt     <= '0;
            rx_q        <= 1'b1;
            shift_en_q  <= 1'b0;
            shift_bit_q <= 1'b0;
            clear_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_next;
            bit_cnt     <= bit_next;
            rx_q        <= rx_s;
            shift_en_q  <= shift_en_d;
            shift_bit_q <= shift_bit_d;
            clear_q     <= clear_d;
            done_q      <= done_d;
            err_q       <= err_d;
            busy_q      <= (state_next != IDLE);
        end
    end

    assign bus.shift_en_o  = shift_en_q;
    assign bus.shift_bit_o = shift_bit_q;
    assign bus.clear_o     = clear_q;
    assign bus.rx_done_o   = done_q;
    assign bus.frame_err_o = err_q;
    assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with CLKS_PER_BIT=8 driving a behavioural LSB-first SIPO.
module tb_uart_rx_ctrl;

    localparam int CPB     = 8;
    localparam int DONE_AT = 79;  // line-drive cycle to rx_done_o: 2 sync + 4 half + 9*8 + 1
    localparam int CLR_AT  = 3;   // line-drive cycle to clear_o: 2 sync + 1

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int cyc = 0;
    int clear_cnt = 0, clear_cyc = 0;
    int shift_cnt = 0;
    int done_cnt = 0, done_cyc = 0, prev_done_cyc = 0;
    int err_cnt = 0, err_cyc = 0;
    int overlap_cnt = 0;
    logic [7:0] shift_byte = '0;
    logic [7:0] sipo;
    logic [7:0] sipo_at_done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream SIPO: enable has priority over clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sipo <= '0;
        else if (bus.shift_en_o) sipo <= {bus.shift_bit_o, sipo[7:1]};
        else if (bus.clear_o) sipo <= '0;
    end

    always @(negedge clk) begin
        if (bus.clear_o) begin
            clear_cnt <= clear_cnt + 1;
            clear_cyc <= cyc;
        end
        if (bus.shift_en_o) begin
            shift_cnt  <= shift_cnt + 1;
            shift_byte <= {bus.shift_bit_o, shift_byte[7:1]};
        end
        if (bus.rx_done_o) begin
            done_cnt      <= done_cnt + 1;
            prev_done_cyc <= done_cyc;
            done_cyc      <= cyc;
            sipo_at_done  <= sipo;
        end
        if (bus.frame_err_o) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if ((bus.shift_en_o && bus.clear_o) || (bus.rx_done_o && bus.frame_err_o))
            overlap_cnt <= overlap_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.shift_en_o, bus.shift_bit_o, bus.clear_o,
                bus.rx_done_o, bus.frame_err_o, bus.busy_o};
    endfunction

    task automatic drive_bit(input logic b);
        bus.rx_i = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_i = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, output int c0);
        c0 = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(stop_bit);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic check_frame_ok(input string tag, input logic [7:0] data, input int c0,
                                  input int done0, input int err0, input int sh0);
        check({tag, " done count"}, done_cnt - done0, 1);
        check({tag, " err count"}, err_cnt - err0, 0);
        check({tag, " shift pulses"}, shift_cnt - sh0, 8);
        check({tag, " shift bits"}, shift_byte, data);
        check({tag, " sipo out"}, sipo_at_done, data);
        check({tag, " done cycle"}, done_cyc - c0, DONE_AT);
    endtask

    initial begin
        int c0, c1, d0, e0, s0, k0;

        bus.rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", outs(), 6'b0);
        rst = 1'b0;
        idle(6);
        check("idle outputs", outs(), 6'b0);

        // 0xA5 clean frame
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'hA5, 1'b1, c0);
        check_frame_ok("a5", 8'hA5, c0, d0, e0, s0);
        check("a5 clear cycle", clear_cyc - c0, CLR_AT);
        idle(4);

        // Stop bit low, then a good 0x3C
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'hA5, 1'b0, c0);
        check("ferr err count", err_cnt - e0, 1);
        check("ferr done count", done_cnt - d0, 0);
        check("ferr err cycle", err_cyc - c0, DONE_AT);
        idle(16);
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'h3C, 1'b1, c0);
        check_frame_ok("3c", 8'h3C, c0, d0, e0, s0);
        idle(4);

        // Two-cycle low glitch on an idle line
        k0 = clear_cnt; s0 = shift_cnt; d0 = done_cnt; e0 = err_cnt;
        c0 = cyc;
        bus.rx_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.rx_i = 1'b1;
        wait_cyc(c0 + 6);
        check("glitch busy at eval", bus.busy_o, 1'b1);
        wait_cyc(c0 + 7);
        check("glitch busy after", bus.busy_o, 1'b0);
        @(posedge clk);
        #1;
        idle(8);
        check("glitch clear count", clear_cnt - k0, 1);
        check("glitch clear cycle", clear_cyc - c0, CLR_AT);
        check("glitch no shift", shift_cnt - s0, 0);
        check("glitch no done/err", (done_cnt - d0) + (err_cnt - e0), 0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'h00, 1'b1, c0);
        check_frame_ok("b2b 00", 8'h00, c0, d0, e0, s0);
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'hFF, 1'b1, c1);
        check_frame_ok("b2b ff", 8'hFF, c1, d0, e0, s0);
        check("b2b done spacing", done_cyc - prev_done_cyc, 80);
        idle(4);

        // Reset asserted during data bit 4
        d0 = done_cnt; e0 = err_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(k0 == -1 ? 1'b0 : 8'h5A >> i & 8'h01 ? 1'b1 : 1'b0);
        bus.rx_i = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("mid-frame busy", bus.busy_o, 1'b1);
        rst = 1'b1;
        #1;
        check("reset mid-frame outputs", outs(), 6'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(20);
        check("reset no done/err", (done_cnt - d0) + (err_cnt - e0), 0);
        check("after reset outputs", outs(), 6'b0);
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'h5A, 1'b1, c0);
        check_frame_ok("5a", 8'h5A, c0, d0, e0, s0);
        idle(4);

        // Framing error followed by a long break, then 0x81
        d0 = done_cnt; e0 = err_cnt;
        send_frame(8'h42, 1'b0, c0);
        check("break err count", err_cnt - e0, 1);
        k0 = clear_cnt;
        bus.rx_i = 1'b0;
        repeat (30 * CPB) @(posedge clk);
        #1;
        check("break no clear", clear_cnt - k0, 0);
        check("break busy", bus.busy_o, 1'b0);
        check("break single err", err_cnt - e0, 1);
        check("break no done", done_cnt - d0, 0);
        idle(8);
        d0 = done_cnt; e0 = err_cnt; s0 = shift_cnt;
        send_frame(8'h81, 1'b1, c0);
        check_frame_ok("81", 8'h81, c0, d0, e0, s0);
        idle(4);

        check("pulse exclusivity", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side UART control FSM that sits directly upstream of the LSB-first SIPO shift register. It synchronises the raw rx line, detects and qualifies the start bit, and samples each bit at mid-bit. It drives the SIPO's shift-enable, serial data and clear inputs, checks the stop bit, and flags frame completion or framing error. Format is fixed at 8N1: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 4, even values only
CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter (derived; not overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
rx_i  input  1  raw serial line, asynchronous, idle high
shift_en_o  output  1  one-cycle pulse; connects to SIPO enb
shift_bit_o  output  1  sampled data bit, valid while shift_en_o=1; connects to SIPO inp
clear_o  output  1  one-cycle pulse at start-edge detect; connects to SIPO clear
rx_done_o  output  1  one-cycle pulse: frame received with a valid stop bit; SIPO out is valid from this cycle
frame_err_o  output  1  one-cycle pulse: stop bit sampled low
busy_o  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high, on ports clk and rst.
- Reset values: state=IDLE, baud_cnt=0, bit_cnt=0, both synchroniser flops=1. All outputs are 0.
- Reset mid-frame: immediate return to IDLE. No rx_done_o or frame_err_o pulse is produced.
- Synchroniser: 2-FF chain produces rx_s. Edge detect compares rx_s with a registered copy rx_q (rx_q resets to 1).
- All outputs are registered. "Pulse at event cycle N" means the output is high during cycle N+1 only.
- HALF = CLKS_PER_BIT/2.
- IDLE:
  - On falling edge (rx_q=1, rx_s=0) at cycle E: clear_o pulse, baud_cnt<=0, go START.
  - A line held low never creates a second edge. A break condition is therefore ignored until the line returns high.
- START:
  - baud_cnt increments each cycle. Evaluate when baud_cnt==HALF-1 (cycle E+HALF).
  - rx_s=0: go DATA, baud_cnt<=0, bit_cnt<=0.
  - rx_s=1: glitch; go IDLE silently. No shift_en_o, rx_done_o or frame_err_o.
- DATA:
  - baud_cnt increments. At baud_cnt==CLKS_PER_BIT-1: shift_en_o pulse, shift_bit_o=rx_s, baud_cnt<=0, bit_cnt++.
  - Bit k is sampled at cycle E+HALF+(k+1)*CLKS_PER_BIT.
  - After the sample with bit_cnt==7: go STOP. bit_cnt is 3 bits wide and wraps to 0.
- STOP:
  - Same counting. At baud_cnt==CLKS_PER_BIT-1 (cycle E+HALF+9*CLKS_PER_BIT): go IDLE.
  - rx_s=1: rx_done_o pulse.
  - rx_s=0: frame_err_o pulse.
  - rx_done_o and frame_err_o are mutually exclusive.
  - The SIPO already holds the 8 bits; no shift occurs in STOP.
- Pulse exclusivity: shift_en_o and clear_o are never high in the same cycle, so the SIPO's enb-over-clear priority is never exercised.
- shift_bit_o holds its last value when shift_en_o=0.
- Back-to-back frames: a falling edge seen in the first IDLE cycle after STOP is accepted. No dead time is required.
- Line changes at non-sample cycles have no effect.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, STOP), 2-bit
  - UART_DATA_BITS=8
  - default CLKS_PER_BIT
- Sub-module sync_2ff: 2-flop synchroniser with parameterised reset value (1 here), asynchronous active-high reset.
- Top level:
  - instantiates sync_2ff
  - FSM, baud counter and bit counter inline
  - test top connects uart_rx_ctrl to sipo_lsb

Test Plan:
- CLKS_PER_BIT=8; send 0xA5 8N1 (line: 0, then 1,0,1,0,0,1,0,1, then 1) -> 8 shift_en_o pulses with shift_bit_o sequence 1,0,1,0,0,1,0,1; rx_done_o pulse at E+4+72+1; SIPO out=0xA5; frame_err_o stays 0.
- Same frame with stop bit driven 0 -> frame_err_o pulse once; rx_done_o stays 0; next valid frame 0x3C after line returns high -> rx_done_o pulse, out=0x3C.
- Low glitch of 2 cycles on idle line -> clear_o pulse; return to IDLE at E+4; no shift_en_o; busy_o low again.
- Frames 0x00 then 0xFF back-to-back, no idle gap -> two rx_done_o pulses exactly 80 cycles apart; out=0x00, then 0xFF.
- rst asserted during data bit 4 of a frame -> all outputs 0 immediately; no done/err pulse; next full frame 0x5A received correctly.
- Line held low for 30 bit times after a framing error -> no new frame starts until rx high then low; then 0x81 received correctly.
